// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row drive, column synchronizer, per-row capture,
// single-press decode and a scan-level debounce that commits a key code plus strobe.
module keypad_scanner #(
    parameter int         SCAN_DIV       = 4,
    parameter int         DEBOUNCE_SCANS = 3,
    parameter logic [3:0] NO_KEY         = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key,
    output logic       key_strobe
);
    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_N    = 4'(DEBOUNCE_SCANS);

    typedef enum logic {TRACKING, COMMIT} state_t;

    logic [3:0] sync1_q, sync2_q;
    logic [7:0] div_q;
    logic [1:0] row_q, row_d;
    logic [3:0] row_n_q;
    logic       row_last;
    logic       scan_done;

    state_t     state_q;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] key_q;
    logic       key_strobe_q;

    logic [15:0] press_all;
    logic [4:0]  n_pressed;
    logic [3:0]  press_idx;
    logic [3:0]  scan_result;

    assign row_d     = row_q + 2'd1;
    assign row_last  = (div_q == DIV_LAST);
    assign scan_done = row_last && (row_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            div_q   <= '0;
            row_q   <= '0;
            row_n_q <= 4'b1110;
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
            if (row_last) begin
                div_q   <= '0;
                row_q   <= row_d;
                row_n_q <= ~(4'b0001 << row_d);
            end else begin
                div_q <= div_q + 8'd1;
            end
        end
    end

    // Rows 0-2 are held here as active-high press vectors; row 3 is used live at evaluation.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cap
        logic [3:0] press_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                press_q <= '0;
            end else if (row_last && (row_q == 2'(gi))) begin
                press_q <= ~sync2_q;
            end
        end
    end

    // Position (3,3) is unassigned, so it is masked out before counting presses.
    assign press_all = {~sync2_q, g_cap[2].press_q, g_cap[1].press_q, g_cap[0].press_q}
                       & 16'h7FFF;

    always_comb begin
        n_pressed = '0;
        press_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (press_all[i]) begin
                n_pressed = n_pressed + 5'd1;
                press_idx = 4'(i);
            end
        end
    end

    always_comb begin
        scan_result = NO_KEY;
        if (n_pressed == 5'd1) begin
            case (press_idx)
                4'd0:    scan_result = 4'd1;
                4'd1:    scan_result = 4'd2;
                4'd2:    scan_result = 4'd3;
                4'd3:    scan_result = 4'd10;
                4'd4:    scan_result = 4'd4;
                4'd5:    scan_result = 4'd5;
                4'd6:    scan_result = 4'd6;
                4'd7:    scan_result = 4'd11;
                4'd8:    scan_result = 4'd7;
                4'd9:    scan_result = 4'd8;
                4'd10:   scan_result = 4'd9;
                4'd11:   scan_result = 4'd12;
                4'd12:   scan_result = 4'd13;
                4'd13:   scan_result = 4'd0;
                4'd14:   scan_result = 4'd14;
                default: scan_result = NO_KEY;
            endcase
        end
    end

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (scan_result == cand_q) begin
            if (cnt_q != DEB_N) begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            cand_d = scan_result;
            cnt_d  = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= TRACKING;
            cand_q       <= NO_KEY;
            cnt_q        <= '0;
            key_q        <= NO_KEY;
            key_strobe_q <= 1'b0;
        end else begin
            key_strobe_q <= 1'b0;
            case (state_q)
                TRACKING: begin
                    if (scan_done) begin
                        cand_q <= cand_d;
                        cnt_q  <= cnt_d;
                        if ((cnt_d == DEB_N) && (cand_d != key_q)) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    key_q        <= cand_q;
                    key_strobe_q <= (cand_q != NO_KEY);
                    state_q      <= TRACKING;
                end
                default: state_q <= TRACKING;
            endcase
        end
    end

    assign row_n      = row_n_q;
    assign key        = key_q;
    assign key_strobe = key_strobe_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Scan-window bench: each call presents one keypad matrix for a full scan and checks
// row drive, strobes and key observed in that window against a table or a history model.
module tb_keypad_scanner;
    localparam int SD  = 4;
    localparam int DS  = 3;
    localparam int WIN = 4 * SD;

    localparam logic [15:0] K1  = 16'h0001;
    localparam logic [15:0] K2  = 16'h0002;
    localparam logic [15:0] K10 = 16'h0008;
    localparam logic [15:0] K4  = 16'h0010;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K8  = 16'h0200;
    localparam logic [15:0] K33 = 16'h8000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col_n, row_n, key;
    logic        key_strobe;
    logic [15:0] matrix = '0;

    int checks = 0;
    int errors = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .NO_KEY(4'hF)) dut (
        .clk(clk), .reset(reset), .col_n(col_n),
        .row_n(row_n), .key(key), .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    // Passive switch matrix: a pressed switch pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) col_n = col_n & ~matrix[r*4 +: 4];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: key map by position, run length of identical scan results.
    logic [3:0] codes [16] = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
                               4'd7, 4'd8, 4'd9, 4'd12, 4'd13, 4'd0, 4'd14, 4'hF};
    logic [3:0] hist [$];
    logic [3:0] mkey;
    bit         mstrobe;

    function automatic logic [3:0] decode(input logic [15:0] m);
        int n = 0;
        logic [3:0] c = 4'hF;
        for (int i = 0; i < 15; i++) begin
            if (m[i]) begin
                n++;
                c = codes[i];
            end
        end
        return (n == 1) ? c : 4'hF;
    endfunction

    task automatic model_reset();
        hist.delete();
        mkey    = 4'hF;
        mstrobe = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] m);
        logic [3:0] r = decode(m);
        int run = 0;
        hist.push_back(r);
        for (int i = hist.size() - 1; i >= 0 && hist[i] == r; i--) run++;
        mstrobe = 1'b0;
        if (run >= DS && r != mkey) begin
            mkey    = r;
            mstrobe = (r != 4'hF);
        end
    endtask

    task automatic run_scan(input logic [15:0] m, input logic [3:0] ek, input bit es,
                            input string tag);
        int ns = 0;
        int rowbad = 0;
        logic [3:0] ks = '0;
        logic [3:0] er;
        matrix = m;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            er = ~(4'b0001 << (i / SD));
            if (key_strobe) ns++;
            if (row_n !== er) rowbad++;
            if (i == WIN - 1) ks = key;
        end
        @(posedge clk); #1;
        check({tag, " row_n sequence errors"}, rowbad, 0);
        check({tag, " strobe count"}, ns, 32'(es));
        check({tag, " key"}, ks, ek);
        $display("scan %s matrix=%04h key=%0d strobes=%0d", tag, m, ks, ns);
    endtask

    task automatic scan_model(input logic [15:0] m, input string tag);
        run_scan(m, mkey, mstrobe, tag);
        model_scan(m);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        matrix = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [15:0] m;
        logic [3:0]  k;
        bit          s;
    } vec_t;
    vec_t tbl [$];

    initial begin
        logic [15:0] m, prev;

        // Expected key/strobe are what each window shows, i.e. the effect of earlier scans.
        tbl.push_back('{K5, 4'hF, 0});      tbl.push_back('{K5, 4'hF, 0});
        tbl.push_back('{K5, 4'hF, 0});      tbl.push_back('{K5, 4'd5, 1});
        tbl.push_back('{16'h0, 4'd5, 0});   tbl.push_back('{16'h0, 4'd5, 0});
        tbl.push_back('{16'h0, 4'd5, 0});   tbl.push_back('{16'h0, 4'hF, 0});
        tbl.push_back('{K1|K2, 4'hF, 0});   tbl.push_back('{K1|K2, 4'hF, 0});
        tbl.push_back('{K1|K2, 4'hF, 0});   tbl.push_back('{K1, 4'hF, 0});
        tbl.push_back('{K1, 4'hF, 0});      tbl.push_back('{K1, 4'hF, 0});
        tbl.push_back('{K1, 4'd1, 1});      tbl.push_back('{K8, 4'd1, 0});
        tbl.push_back('{K8, 4'd1, 0});      tbl.push_back('{K8, 4'd1, 0});
        tbl.push_back('{K4, 4'd8, 1});      tbl.push_back('{K4, 4'd8, 0});
        tbl.push_back('{K4, 4'd8, 0});      tbl.push_back('{K33, 4'd4, 1});
        tbl.push_back('{K33, 4'd4, 0});     tbl.push_back('{K33, 4'd4, 0});
        tbl.push_back('{K10, 4'hF, 0});     tbl.push_back('{16'h0, 4'hF, 0});
        tbl.push_back('{K10, 4'hF, 0});     tbl.push_back('{16'h0, 4'hF, 0});
        tbl.push_back('{K10, 4'hF, 0});     tbl.push_back('{K10, 4'hF, 0});
        tbl.push_back('{K10, 4'hF, 0});     tbl.push_back('{K10, 4'd10, 1});
        tbl.push_back('{K10, 4'd10, 0});

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("reset key", key, 4'hF);
        check("reset row_n", row_n, 4'b1110);
        check("reset strobe", key_strobe, 1'b0);

        foreach (tbl[i]) run_scan(tbl[i].m, tbl[i].k, tbl[i].s, $sformatf("tbl%0d", i));

        // Reset while a key is committed and still held.
        do_reset();
        model_reset();
        for (int i = 0; i < 5; i++) scan_model(K5, $sformatf("hold5_%0d", i));
        matrix = K5;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midscan reset key", key, 4'hF);
        check("midscan reset row_n", row_n, 4'b1110);
        check("midscan reset strobe", key_strobe, 1'b0);
        model_reset();
        for (int i = 0; i < 5; i++) scan_model(K5, $sformatf("redetect5_%0d", i));

        // Random matrices with persistence so some keys survive debounce.
        do_reset();
        model_reset();
        prev = '0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 99) < 65) begin
                m = prev;
            end else begin
                case ($urandom_range(0, 3))
                    0: m = '0;
                    1: m = 16'h1 << $urandom_range(0, 15);
                    2: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                    default: m = K33 | (16'h1 << $urandom_range(0, 14));
                endcase
            end
            prev = m;
            scan_model(m, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
